l1_i_assoc: RTL and testbench

L1_I_ASSOC -- requirements
Module: l1_i_assoc

---
 rtl/l1_i_assoc.sv | 278 +++++++++++++++++++++++++++
 tb/tb_l1_i_assoc.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_i_assoc.sv
// -----------------------------------------------------------------------------
// l1_i_assoc -- set-associative, read-only L1 instruction cache.
//
// Lookups happen only while the controller is IDLE and are answered
// combinationally in the same cycle. A miss latches the line address, issues
// a single-cycle line-aligned request to L2 and waits for the fill. The fill is
// written into the lowest invalid way of the set. If every way is valid, it
// goes into the way selected by that set's round-robin pointer. FLUSH
// invalidates the whole array. If a flush arrives while a miss is outstanding,
// it is deferred until the controller returns to IDLE.
//
// Ports:
//   clk                sole clock, rising edge
//   reset              synchronous active-high reset
//   S_R_ADDR           fetch address from the core
//   S_R_ADDR_VALID     fetch request valid
//   S_R_DATA           hit line data (zero when S_R_DATA_VALID=0)
//   S_R_DATA_VALID     combinational hit indication
//   FLUSH              invalidate-all request
//   L2_S_R_ADDR        line-aligned miss address to L2 (zero when not valid)
//   L2_S_R_ADDR_VALID  miss request valid, one cycle per miss
//   L2_S_R_DATA        fill line from L2
//   L2_S_R_DATA_VALID  fill data valid (honoured only while waiting)
//   MISS_COUNT         misses since reset, wraps at 2^32
// -----------------------------------------------------------------------------
module l1_i_assoc #(
   parameter  int SETS           = 64,
   parameter  int WAYS           = 2,
   parameter  int BYTES_PER_LINE = 64,
   parameter  int ADDR_WIDTH     = 64,
   localparam int DATA_SIZE      = BYTES_PER_LINE * 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] S_R_ADDR,
   input  logic                  S_R_ADDR_VALID,
   output logic [DATA_SIZE-1:0]  S_R_DATA,
   output logic                  S_R_DATA_VALID,
   input  logic                  FLUSH,
   output logic [ADDR_WIDTH-1:0] L2_S_R_ADDR,
   output logic                  L2_S_R_ADDR_VALID,
   input  logic [DATA_SIZE-1:0]  L2_S_R_DATA,
   input  logic                  L2_S_R_DATA_VALID,
   output logic [31:0]           MISS_COUNT
);

   localparam int INDEX_SIZE  = $clog2(SETS);
   localparam int OFFSET_SIZE = $clog2(BYTES_PER_LINE);
   localparam int TAG_SIZE    = ADDR_WIDTH - INDEX_SIZE - OFFSET_SIZE;
   localparam int WAY_W       = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(BYTES_PER_LINE - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t state_r;
   state_t state_nxt_s;

   // Storage arrays
   logic [WAYS-1:0]      valid_r [SETS];
   logic [TAG_SIZE-1:0]  tag_r   [SETS][WAYS];
   logic [DATA_SIZE-1:0] data_r  [SETS][WAYS];

   // Outstanding-miss context
   logic [INDEX_SIZE-1:0] miss_index_r;
   logic [TAG_SIZE-1:0]   miss_tag_r;
   logic                  flush_pending_r;
   logic [31:0]           miss_count_r;
   logic                  l2_valid_r;
   logic [ADDR_WIDTH-1:0] l2_addr_r;

   // Lookup decode
   logic [INDEX_SIZE-1:0] req_index_s;
   logic [TAG_SIZE-1:0]   req_tag_s;
   logic                  hit_any_s;
   logic [WAY_W-1:0]      hit_way_s;

   // Control qualifiers
   logic                  flush_do_s;
   logic                  lookup_s;
   logic                  hit_s;
   logic                  miss_s;
   logic                  fill_s;

   // Victim selection
   logic                  inv_found_s;
   logic [WAY_W-1:0]      inv_way_s;
   logic [WAY_W-1:0]      rr_cur_s;
   logic [WAY_W-1:0]      victim_way_s;
   logic                  rr_adv_s;

   assign req_index_s = S_R_ADDR[OFFSET_SIZE +: INDEX_SIZE];
   assign req_tag_s   = S_R_ADDR[ADDR_WIDTH-1 -: TAG_SIZE];

   // A pending flush takes the first IDLE cycle, just like a live FLUSH, so
   // no lookup is performed in that cycle.
   assign flush_do_s = (state_r == ST_IDLE) && (FLUSH || flush_pending_r);
   assign lookup_s   = (state_r == ST_IDLE) && S_R_ADDR_VALID && !flush_do_s && !reset;
   assign hit_s      = lookup_s && hit_any_s;
   assign miss_s     = lookup_s && !hit_any_s;
   assign fill_s     = (state_r == ST_WAIT) && L2_S_R_DATA_VALID;

   // Tag compare across the addressed set; the lowest matching way wins
   always_comb begin
      hit_any_s = 1'b0;
      hit_way_s = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!hit_any_s && valid_r[req_index_s][w] && (tag_r[req_index_s][w] == req_tag_s)) begin
            hit_any_s = 1'b1;
            hit_way_s = WAY_W'(w);
         end else begin
            hit_any_s = hit_any_s;
         end
      end
   end

   // Hit data is forced to zero whenever no hit is reported
   always_comb begin
      S_R_DATA_VALID = hit_s;
      if (hit_s) begin
         S_R_DATA = data_r[req_index_s][hit_way_s];
      end else begin
         S_R_DATA = '0;
      end
   end

   // Lowest-numbered invalid way in the set being filled
   always_comb begin
      inv_found_s = 1'b0;
      inv_way_s   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!inv_found_s && !valid_r[miss_index_r][w]) begin
            inv_found_s = 1'b1;
            inv_way_s   = WAY_W'(w);
         end else begin
            inv_found_s = inv_found_s;
         end
      end
   end

   // Use an invalid way if one exists; otherwise take the RR pointer
   always_comb begin
      if (inv_found_s) begin
         victim_way_s = inv_way_s;
      end else begin
         victim_way_s = rr_cur_s;
      end
   end

   // The pointer moves only when it actually chose the victim
   assign rr_adv_s = fill_s && !inv_found_s;

   generate
      if (WAYS > 1) begin : g_rr
         logic [WAY_W-1:0] rr_r [SETS];

         assign rr_cur_s = rr_r[miss_index_r];

         // Per-set round-robin pointers; WAYS is a power of two so the
         // increment wraps modulo WAYS naturally
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int s = 0; s < SETS; s++) begin
                  rr_r[s] <= '0;
               end
            end else if (flush_do_s) begin
               for (int s = 0; s < SETS; s++) begin
                  rr_r[s] <= '0;
               end
            end else if (rr_adv_s) begin
               rr_r[miss_index_r] <= rr_r[miss_index_r] + WAY_W'(1);
            end else begin
               rr_r[miss_index_r] <= rr_r[miss_index_r];
            end
         end
      end else begin : g_no_rr
         assign rr_cur_s = '0;
      end
   endgenerate

   // Valid bits: cleared by reset or flush, set by a fill
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < SETS; s++) begin
            valid_r[s] <= '0;
         end
      end else if (flush_do_s) begin
         for (int s = 0; s < SETS; s++) begin
            valid_r[s] <= '0;
         end
      end else if (fill_s) begin
         valid_r[miss_index_r][victim_way_s] <= 1'b1;
      end else begin
         valid_r[miss_index_r] <= valid_r[miss_index_r];
      end
   end

   // Tag and data arrays need no reset because the valid bits qualify them
   always_ff @(posedge clk) begin
      if (fill_s) begin
         tag_r[miss_index_r][victim_way_s]  <= miss_tag_r;
         data_r[miss_index_r][victim_way_s] <= L2_S_R_DATA;
      end
   end

   // Controller state register and miss bookkeeping
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r         <= ST_IDLE;
         miss_index_r    <= '0;
         miss_tag_r      <= '0;
         flush_pending_r <= 1'b0;
         miss_count_r    <= 32'd0;
         l2_valid_r      <= 1'b0;
         l2_addr_r       <= '0;
      end else begin
         state_r <= state_nxt_s;
         if (miss_s) begin
            miss_index_r <= req_index_s;
            miss_tag_r   <= req_tag_s;
            miss_count_r <= miss_count_r + 32'd1;
         end else begin
            miss_index_r <= miss_index_r;
            miss_tag_r   <= miss_tag_r;
            miss_count_r <= miss_count_r;
         end
         if ((state_r != ST_IDLE) && FLUSH) begin
            flush_pending_r <= 1'b1;
         end else if (flush_do_s) begin
            flush_pending_r <= 1'b0;
         end else begin
            flush_pending_r <= flush_pending_r;
         end
         // The registered request is high exactly during the REQ cycle.
         l2_valid_r <= miss_s;
         if (miss_s) begin
            l2_addr_r <= S_R_ADDR & ~OFFSET_MASK;
         end else begin
            l2_addr_r <= '0;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (miss_s) begin
               state_nxt_s = ST_REQ;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            state_nxt_s = ST_WAIT;
         end
         ST_WAIT: begin
            if (L2_S_R_DATA_VALID) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   assign L2_S_R_ADDR_VALID = l2_valid_r;
   assign L2_S_R_ADDR       = l2_addr_r;
   assign MISS_COUNT        = miss_count_r;

endmodule

// File: tb/tb_l1_i_assoc.sv
// -----------------------------------------------------------------------------
// tb_l1_i_assoc -- scoreboard bench for l1_i_assoc (64 sets, 2 ways, 64-byte
// lines, 64-bit addresses). Stimulus pushes the expected response (L2 request
// address or hit data) into a queue. A negedge monitor pops an entry and
// compares it whenever the DUT raises S_R_DATA_VALID or L2_S_R_ADDR_VALID.
// All test addresses below 0x4000 map to set 0; 0x1040 maps to set 1.
// -----------------------------------------------------------------------------
module tb_l1_i_assoc;

   localparam int AW = 64;
   localparam int DW = 512;

   logic          clk;
   logic          reset;
   logic [AW-1:0] S_R_ADDR;
   logic          S_R_ADDR_VALID;
   logic [DW-1:0] S_R_DATA;
   logic          S_R_DATA_VALID;
   logic          FLUSH;
   logic [AW-1:0] L2_S_R_ADDR;
   logic          L2_S_R_ADDR_VALID;
   logic [DW-1:0] L2_S_R_DATA;
   logic          L2_S_R_DATA_VALID;
   logic [31:0]   MISS_COUNT;

   l1_i_assoc #(
      .SETS(64), .WAYS(2), .BYTES_PER_LINE(64), .ADDR_WIDTH(64)
   ) dut (
      .clk(clk),
      .reset(reset),
      .S_R_ADDR(S_R_ADDR),
      .S_R_ADDR_VALID(S_R_ADDR_VALID),
      .S_R_DATA(S_R_DATA),
      .S_R_DATA_VALID(S_R_DATA_VALID),
      .FLUSH(FLUSH),
      .L2_S_R_ADDR(L2_S_R_ADDR),
      .L2_S_R_ADDR_VALID(L2_S_R_ADDR_VALID),
      .L2_S_R_DATA(L2_S_R_DATA),
      .L2_S_R_DATA_VALID(L2_S_R_DATA_VALID),
      .MISS_COUNT(MISS_COUNT)
   );

   typedef struct {
      logic          is_hit;
      logic [DW-1:0] val;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Line pattern generator: 16 distinct 32-bit words derived from a seed
   function automatic logic [DW-1:0] mk(input logic [31:0] s);
      logic [DW-1:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         r[i*32 +: 32] = s + 32'(i) * 32'h0101_0101;
      end
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, got, want);
      end
   endtask

   task automatic push_l2(input logic [AW-1:0] a);
      exp_t e;
      e.is_hit = 1'b0;
      e.val    = DW'(a);
      sb.push_back(e);
   endtask

   task automatic push_hit(input logic [DW-1:0] d);
      exp_t e;
      e.is_hit = 1'b1;
      e.val    = d;
      sb.push_back(e);
   endtask

   task automatic reset_dut();
      reset             = 1'b1;
      S_R_ADDR_VALID    = 1'b0;
      FLUSH             = 1'b0;
      L2_S_R_DATA_VALID = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   // Present a missing address in IDLE; returns in the REQ cycle
   task automatic start_miss(input logic [AW-1:0] a);
      push_l2(a & ~64'h3F);
      S_R_ADDR       = a;
      S_R_ADDR_VALID = 1'b1;
      step();
   endtask

   // From the REQ cycle: wait dly WAIT cycles, fill d, observe one hit, release
   task automatic wait_fill(input logic [DW-1:0] d, input int dly);
      step();
      repeat (dly) step();
      L2_S_R_DATA       = d;
      L2_S_R_DATA_VALID = 1'b1;
      push_hit(d);
      step();
      L2_S_R_DATA_VALID = 1'b0;
      step();
      S_R_ADDR_VALID = 1'b0;
   endtask

   task automatic miss_fill(input logic [AW-1:0] a, input logic [DW-1:0] d, input int dly);
      start_miss(a);
      wait_fill(d, dly);
   endtask

   task automatic lookup_hit(input logic [AW-1:0] a, input logic [DW-1:0] d);
      push_hit(d);
      S_R_ADDR       = a;
      S_R_ADDR_VALID = 1'b1;
      step();
      S_R_ADDR_VALID = 1'b0;
   endtask

   // Monitor: every presented output must match the head of the scoreboard
   always @(negedge clk) begin
      if (S_R_DATA_VALID || L2_S_R_ADDR_VALID) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output dv=%0b l2v=%0b l2addr=%0h", S_R_DATA_VALID,
                     L2_S_R_ADDR_VALID, L2_S_R_ADDR);
         end else begin
            mon_e = sb.pop_front();
            if (mon_e.is_hit) begin
               if (!S_R_DATA_VALID || L2_S_R_ADDR_VALID || (S_R_DATA !== mon_e.val)) begin
                  errors++;
                  $display("FAIL hit_data dv=%0b l2v=%0b got %0h want %0h", S_R_DATA_VALID,
                           L2_S_R_ADDR_VALID, S_R_DATA[63:0], mon_e.val[63:0]);
               end
            end else begin
               if (!L2_S_R_ADDR_VALID || S_R_DATA_VALID || (L2_S_R_ADDR !== mon_e.val[AW-1:0])) begin
                  errors++;
                  $display("FAIL l2_req dv=%0b l2v=%0b got %0h want %0h", S_R_DATA_VALID,
                           L2_S_R_ADDR_VALID, L2_S_R_ADDR, mon_e.val[AW-1:0]);
               end
            end
         end
      end
      if ((!S_R_DATA_VALID && (S_R_DATA !== '0)) || (!L2_S_R_ADDR_VALID && (L2_S_R_ADDR !== '0))) begin
         checks++;
         errors++;
         $display("FAIL idle_zero data_nonzero=%0b l2addr=%0h", |S_R_DATA, L2_S_R_ADDR);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      reset             = 1'b1;
      S_R_ADDR          = '0;
      S_R_ADDR_VALID    = 1'b0;
      FLUSH             = 1'b0;
      L2_S_R_DATA       = '0;
      L2_S_R_DATA_VALID = 1'b0;
      reset_dut();

      // Reset state
      check("rst_miss_count", 64'(MISS_COUNT), 64'd0);
      check("rst_data_valid", 64'(S_R_DATA_VALID), 64'd0);
      check("rst_l2_valid", 64'(L2_S_R_ADDR_VALID), 64'd0);
      check("rst_l2_addr", L2_S_R_ADDR, 64'd0);
      check("rst_data_zero", 64'(|S_R_DATA), 64'd0);

      // Cold miss: 0x1024 -> request 0x1000, fill after 3 cycles, then hit
      miss_fill(64'h1024, mk(32'hD1D1_0000), 3);
      check("cold_miss_count", 64'(MISS_COUNT), 64'd1);

      // Replacement in set 0
      reset_dut();
      miss_fill(64'h1000, mk(32'hA000_0000), 1);   // way0
      miss_fill(64'h2000, mk(32'hB000_0000), 2);   // way1
      lookup_hit(64'h1000, mk(32'hA000_0000));
      lookup_hit(64'h2004, mk(32'hB000_0000));
      miss_fill(64'h3000, mk(32'hC000_0000), 0);   // evicts way0, rr -> 1
      lookup_hit(64'h2000, mk(32'hB000_0000));
      lookup_hit(64'h3000, mk(32'hC000_0000));
      miss_fill(64'h1000, mk(32'hA200_0000), 1);   // evicts way1 (0x2000), rr -> 0
      check("repl_miss_count", 64'(MISS_COUNT), 64'd4);
      lookup_hit(64'h3000, mk(32'hC000_0000));
      lookup_hit(64'h103C, mk(32'hA200_0000));
      miss_fill(64'h1040, mk(32'hE000_0000), 1);   // set 1
      lookup_hit(64'h1000, mk(32'hA200_0000));
      lookup_hit(64'h1040, mk(32'hE000_0000));
      check("set1_miss_count", 64'(MISS_COUNT), 64'd5);

      // Flush in IDLE together with a would-be hit: flush wins, nothing counted
      S_R_ADDR       = 64'h3000;
      S_R_ADDR_VALID = 1'b1;
      FLUSH          = 1'b1;
      step();
      FLUSH          = 1'b0;
      S_R_ADDR_VALID = 1'b0;
      check("flush_no_count", 64'(MISS_COUNT), 64'd5);
      miss_fill(64'h2000, mk(32'hB200_0000), 1);
      miss_fill(64'h3000, mk(32'hC200_0000), 1);
      check("post_flush_count", 64'(MISS_COUNT), 64'd7);

      // Flush in WAIT: the fill completes, the first IDLE cycle is silent,
      // then the same address misses again
      start_miss(64'h1000);
      step();                                  // WAIT
      FLUSH = 1'b1;
      step();
      FLUSH             = 1'b0;
      L2_S_R_DATA       = mk(32'h3500_0000);
      L2_S_R_DATA_VALID = 1'b1;
      step();                                  // first IDLE, flush pending
      L2_S_R_DATA_VALID = 1'b0;
      push_l2(64'h1000);
      step();                                  // flush applied at this edge
      step();                                  // miss detected -> REQ
      wait_fill(mk(32'h3501_0000), 1);
      check("flush_wait_count", 64'(MISS_COUNT), 64'd9);
      lookup_hit(64'h1000, mk(32'h3501_0000));

      // Reset during WAIT aborts the miss; the late fill must be ignored
      reset_dut();
      start_miss(64'h1000);
      step();                                  // WAIT
      reset          = 1'b1;
      S_R_ADDR_VALID = 1'b0;
      step();
      reset = 1'b0;
      check("rst_wait_count", 64'(MISS_COUNT), 64'd0);
      L2_S_R_DATA       = mk(32'hD9D9_0000);
      L2_S_R_DATA_VALID = 1'b1;
      step();
      L2_S_R_DATA_VALID = 1'b0;
      miss_fill(64'h1000, mk(32'h1010_0000), 1);
      check("rst_wait_miss_count", 64'(MISS_COUNT), 64'd1);

      // Spurious fill in IDLE after reset: no storage change
      reset_dut();
      L2_S_R_DATA       = mk(32'h5555_0000);
      L2_S_R_DATA_VALID = 1'b1;
      step();
      L2_S_R_DATA_VALID = 1'b0;
      check("spurious_count", 64'(MISS_COUNT), 64'd0);
      miss_fill(64'h1000, mk(32'h1111_0000), 1);
      miss_fill(64'h0000, mk(32'h2222_0000), 1);
      check("spurious_miss_count", 64'(MISS_COUNT), 64'd2);

      step();
      step();
      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
